// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: parametrised single-port SRAM slave on a valid/ready bus.
//
// Adds byte-enabled writes, a pipelined read response of fixed latency,
// programmable wait states after every accepted transfer, and one-cycle error
// strobes for addresses at or beyond DEPTH.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous reset, active high (memory contents are kept)
//   i_addr     word address
//   i_wr_data  write data
//   i_be       byte enables for writes
//   i_wr_rd    1 = write, 0 = read
//   i_valid    request valid
//   o_ready    slave accepts a request this cycle
//   o_rd_data  read response data, held while o_rd_valid is low
//   o_rd_valid one-cycle strobe qualifying o_rd_data
//   o_err      one-cycle out-of-range strobe
module sram_mem_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic                i_wr_rd,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [DATA_W-1:0]   o_rd_data,
    output logic                o_rd_valid,
    output logic                o_err
);

    localparam int unsigned NB      = DATA_W / 8;
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic {StAccept, StWait} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [2:0]        r_wait_cnt;
    logic [2:0]        w_wait_cnt_next;

    logic              w_accept;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_word;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [RD_LAT-1:0] r_pipe_err;
    logic [DATA_W-1:0] r_pipe_data [RD_LAT];
    logic              r_wr_err;

    assign o_ready    = (r_state == StAccept);
    // Reset wins over a coincident request so nothing is accepted on a reset edge.
    assign w_accept   = i_valid & o_ready & ~i_rst;
    // No address wrap: anything at or above DEPTH is an error.
    assign w_in_range = (32'(i_addr) < DEPTH);
    assign w_idx      = i_addr[IDX_W-1:0];
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

    // Reset parks the FSM in StWait with a zero count, so ready rises on the
    // first edge after reset is released.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StWait;
            r_wait_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            StAccept: begin
                if (w_accept && (WAIT_STATES > 0)) begin
                    w_state_next    = StWait;
                    w_wait_cnt_next = WS_LOAD;
                end
            end
            StWait: begin
                if (r_wait_cnt == 3'd0) begin
                    w_state_next = StAccept;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 3'd1;
                end
            end
        endcase
    end

    // Storage array has no reset; contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (w_accept && i_wr_rd && w_in_range) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (i_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read response pipeline of {valid, err, data}. Data only advances behind
    // a valid entry so the last stage holds its value across bubbles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pipe_vld <= '0;
            r_pipe_err <= '0;
            r_wr_err   <= 1'b0;
            for (int s = 0; s < int'(RD_LAT); s++) begin
                r_pipe_data[s] <= '0;
            end
        end else begin
            r_wr_err      <= w_accept & i_wr_rd & ~w_in_range;
            r_pipe_vld[0] <= w_accept & ~i_wr_rd;
            r_pipe_err[0] <= w_accept & ~i_wr_rd & ~w_in_range;
            if (w_accept && !i_wr_rd) begin
                r_pipe_data[0] <= w_rd_word;
            end
            for (int s = 1; s < int'(RD_LAT); s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_err[s] <= r_pipe_err[s-1];
                if (r_pipe_vld[s-1]) begin
                    r_pipe_data[s] <= r_pipe_data[s-1];
                end
            end
        end
    end

    assign o_rd_valid = r_pipe_vld[RD_LAT-1];
    assign o_rd_data  = r_pipe_data[RD_LAT-1];
    assign o_err      = r_wr_err | (r_pipe_vld[RD_LAT-1] & r_pipe_err[RD_LAT-1]);

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: self-checking bench for sram_mem_ctrl.
//
// Three instances share one clock:
//   0: defaults (DEPTH 256, RD_LAT 1, WAIT_STATES 0)
//   1: DEPTH 200, RD_LAT 3, WAIT_STATES 0
//   2: DEPTH 256, RD_LAT 2, WAIT_STATES 2
// Read expectations go into a scoreboard queue when the request is accepted
// and are popped by a monitor when rd_valid appears.
module tb_sram_mem_ctrl;

    localparam int NI = 3;

    typedef struct {
        int          inst;
        logic [15:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic          clk = 1'b0;
    logic [NI-1:0] rst;
    logic [NI-1:0] wr_rd;
    logic [NI-1:0] valid;
    logic [7:0]    addr     [NI];
    logic [15:0]   wdata    [NI];
    logic [1:0]    be       [NI];
    logic          ready    [NI];
    logic [15:0]   rd_data  [NI];
    logic          rd_valid [NI];
    logic          err      [NI];

    exp_t        sb [$];
    logic [15:0] model     [NI][256];
    int          werr_due  [NI];
    logic [15:0] last_data [NI];
    logic        rst_seen  [NI];
    bit          mon_en   = 1'b0;
    int          cyc      = 0;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NI; k++) rst_seen[k] <= rst[k];
    end

    sram_mem_ctrl #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .RD_LAT(1), .WAIT_STATES(0)) u_dut_a (
        .i_clk(clk), .i_rst(rst[0]), .i_addr(addr[0]), .i_wr_data(wdata[0]), .i_be(be[0]),
        .i_wr_rd(wr_rd[0]), .i_valid(valid[0]), .o_ready(ready[0]), .o_rd_data(rd_data[0]),
        .o_rd_valid(rd_valid[0]), .o_err(err[0])
    );

    sram_mem_ctrl #(.ADDR_W(8), .DATA_W(16), .DEPTH(200), .RD_LAT(3), .WAIT_STATES(0)) u_dut_b (
        .i_clk(clk), .i_rst(rst[1]), .i_addr(addr[1]), .i_wr_data(wdata[1]), .i_be(be[1]),
        .i_wr_rd(wr_rd[1]), .i_valid(valid[1]), .o_ready(ready[1]), .o_rd_data(rd_data[1]),
        .o_rd_valid(rd_valid[1]), .o_err(err[1])
    );

    sram_mem_ctrl #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .RD_LAT(2), .WAIT_STATES(2)) u_dut_c (
        .i_clk(clk), .i_rst(rst[2]), .i_addr(addr[2]), .i_wr_data(wdata[2]), .i_be(be[2]),
        .i_wr_rd(wr_rd[2]), .i_valid(valid[2]), .o_ready(ready[2]), .o_rd_data(rd_data[2]),
        .o_rd_valid(rd_valid[2]), .o_err(err[2])
    );

    function automatic int depth_of(input int k);
        return (k == 1) ? 200 : 256;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge before an accept edge; updates the model and
    // schedules the expected response.
    task automatic note_accept(input int k, input logic wr, input logic [7:0] a,
                               input logic [15:0] d, input logic [1:0] b);
        exp_t e;
        if (wr) begin
            if (int'(a) < depth_of(k)) begin
                for (int i = 0; i < 2; i++) begin
                    if (b[i]) model[k][a][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                werr_due[k] = cyc + 1;
            end
        end else begin
            e.inst = k;
            e.err  = !(int'(a) < depth_of(k));
            e.data = e.err ? 16'h0000 : model[k][a];
            e.due  = cyc + lat_of(k);
            sb.push_back(e);
        end
    endtask

    // Starts and ends on a negedge; returns at the negedge after the accept edge.
    task automatic xfer(input int k, input logic wr, input logic [7:0] a,
                        input logic [15:0] d, input logic [1:0] b);
        int tries;
        addr[k]  = a;
        wdata[k] = d;
        be[k]    = b;
        wr_rd[k] = wr;
        valid[k] = 1'b1;
        tries    = 0;
        while (ready[k] !== 1'b1 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 20) begin
            check($sformatf("ready_timeout_%0d", k), 32'(ready[k]), 32'd1);
        end else begin
            note_accept(k, wr, a, d, b);
        end
        @(negedge clk);
        valid[k] = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        int idx;
        if (mon_en) begin
            for (int k = 0; k < NI; k++) begin
                if (rst_seen[k] === 1'b1) last_data[k] = 16'h0000;
                if (rd_valid[k] === 1'b1) begin
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (idx < 0 && sb[i].inst == k) idx = i;
                    end
                    if (idx < 0) begin
                        check($sformatf("spurious_rd_valid_%0d", k), 32'(rd_valid[k]), 32'd0);
                    end else begin
                        check($sformatf("rd_data_%0d", k), 32'(rd_data[k]), 32'(sb[idx].data));
                        check($sformatf("rd_err_%0d", k), 32'(err[k]),
                              32'(sb[idx].err | (werr_due[k] == cyc)));
                        check($sformatf("rd_cycle_%0d", k), cyc, sb[idx].due);
                        last_data[k] = sb[idx].data;
                        sb.delete(idx);
                    end
                end else begin
                    check($sformatf("rd_data_hold_%0d", k), 32'(rd_data[k]), 32'(last_data[k]));
                    check($sformatf("err_idle_%0d", k), 32'(err[k]), 32'(werr_due[k] == cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] pat;
        int         acc;

        rst   = '1;
        valid = '0;
        wr_rd = '0;
        for (int k = 0; k < NI; k++) begin
            addr[k]      = 8'h00;
            wdata[k]     = 16'h0000;
            be[k]        = 2'b00;
            werr_due[k]  = -1;
            last_data[k] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset_ready_%0d", k), 32'(ready[k]), 32'd0);
            check($sformatf("reset_rd_valid_%0d", k), 32'(rd_valid[k]), 32'd0);
            check($sformatf("reset_rd_data_%0d", k), 32'(rd_data[k]), 32'd0);
        end
        rst = '0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("ready_after_reset_%0d", k), 32'(ready[k]), 32'd1);
        end

        // Instance 0: basic write/read and byte enables.
        xfer(0, 1'b1, 8'h10, 16'hBEEF, 2'b11);
        xfer(0, 1'b0, 8'h10, 16'h0000, 2'b00);
        check("a_read_beef_valid", 32'(rd_valid[0]), 32'd1);
        check("a_read_beef_data", 32'(rd_data[0]), 32'h0000BEEF);
        xfer(0, 1'b1, 8'h20, 16'h1234, 2'b11);
        xfer(0, 1'b1, 8'h20, 16'hAB00, 2'b10);
        xfer(0, 1'b1, 8'h20, 16'hFFFF, 2'b00);
        xfer(0, 1'b0, 8'h20, 16'h0000, 2'b00);
        check("a_byte_en_data", 32'(rd_data[0]), 32'h0000AB34);
        repeat (2) @(negedge clk);

        // Instance 1: pipelined reads, range errors, read with write in flight.
        xfer(1, 1'b1, 8'h01, 16'h0001, 2'b11);
        xfer(1, 1'b1, 8'h02, 16'h0002, 2'b11);
        xfer(1, 1'b1, 8'h03, 16'h0003, 2'b11);
        xfer(1, 1'b1, 8'h48, 16'h5555, 2'b11);
        xfer(1, 1'b1, 8'hC7, 16'h7777, 2'b11);
        repeat (2) @(negedge clk);
        xfer(1, 1'b0, 8'h01, 16'h0000, 2'b00);
        xfer(1, 1'b0, 8'h02, 16'h0000, 2'b00);
        xfer(1, 1'b0, 8'h03, 16'h0000, 2'b00);
        repeat (5) @(negedge clk);
        xfer(1, 1'b1, 8'hC8, 16'hDEAD, 2'b11);
        check("b_wr_oor_err", 32'(err[1]), 32'd1);
        xfer(1, 1'b0, 8'h48, 16'h0000, 2'b00);
        xfer(1, 1'b0, 8'hC7, 16'h0000, 2'b00);
        xfer(1, 1'b0, 8'hC8, 16'h0000, 2'b00);
        xfer(1, 1'b0, 8'hFF, 16'h0000, 2'b00);
        repeat (5) @(negedge clk);
        xfer(1, 1'b0, 8'h01, 16'h0000, 2'b00);
        xfer(1, 1'b1, 8'h01, 16'h0A0A, 2'b11);
        xfer(1, 1'b0, 8'h01, 16'h0000, 2'b00);
        repeat (5) @(negedge clk);

        // Instance 2: wait-state ready pattern with valid held high.
        xfer(2, 1'b1, 8'h05, 16'h5A5A, 2'b11);
        repeat (3) @(negedge clk);
        pat      = 6'b001001;
        acc      = 0;
        addr[2]  = 8'h05;
        wr_rd[2] = 1'b0;
        valid[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("c_ws_ready_%0d", i), 32'(ready[2]), 32'(pat[i]));
            if (ready[2] === 1'b1) begin
                note_accept(2, 1'b0, 8'h05, 16'h0000, 2'b00);
                acc++;
            end
            @(negedge clk);
        end
        valid[2] = 1'b0;
        check("c_ws_accepts", acc, 2);
        repeat (6) @(negedge clk);

        // Instance 2: reset on the cycle after a read accept discards it.
        addr[2]  = 8'h05;
        wr_rd[2] = 1'b0;
        valid[2] = 1'b1;
        check("c_pre_rst_ready", 32'(ready[2]), 32'd1);
        @(negedge clk);
        valid[2] = 1'b0;
        rst[2]   = 1'b1;
        @(negedge clk);
        check("c_rst_no_rd_valid", 32'(rd_valid[2]), 32'd0);
        check("c_rst_ready_low", 32'(ready[2]), 32'd0);
        @(negedge clk);
        check("c_rst_ready_low2", 32'(ready[2]), 32'd0);
        rst[2] = 1'b0;
        @(negedge clk);
        check("c_ready_after_release", 32'(ready[2]), 32'd1);
        repeat (5) @(negedge clk);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
